// File: rtl/ol_pkg.sv
// ol_pkg: shared types and constants for the optical-link bring-up controller.
// Link states, lane-skew codes and the default lane-0 alignment word.
package ol_pkg;

    typedef enum logic [1:0] {
        ST_ALIGN = 2'b00,
        ST_TEST  = 2'b01,
        ST_DATA  = 2'b10,
        ST_IDLE  = 2'b11
    } ol_state_t;

    localparam logic [1:0] DM_ADJ   = 2'd0;
    localparam logic [1:0] DM_LAG2  = 2'd1;
    localparam logic [1:0] DM_OTHER = 2'd2;

    localparam logic [15:0] OL_ALIGN_WORD = 16'h50BC;

    function automatic logic [1:0] skew_code(
        input logic [15:0] l0,
        input logic [15:0] l1
    );
        logic [15:0] d10;
        logic [15:0] d01;
        logic [1:0]  code;
        d10 = l1 - l0;
        d01 = l0 - l1;
        if (d10 == 16'd1) begin
            code = DM_ADJ;
        end else if (d01 == 16'd2) begin
            code = DM_LAG2;
        end else begin
            code = DM_OTHER;
        end
        return code;
    endfunction

endpackage

// File: rtl/ol_pattern_checker.sv
// ol_pattern_checker: RX counter-pattern check, lock tracking and skew code.
// Compares each received word with the one before it, lane by lane.
module ol_pattern_checker
    import ol_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int LOCK_COUNT = 2047
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [16*LANES-1:0]   data_rx,
    output logic                  locked,
    output logic [1:0]            delay_mode
);

    localparam int LW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);

    logic [16*LANES-1:0] rx_cur;
    logic [16*LANES-1:0] rx_prev;
    logic [LW-1:0]       lock_cnt;
    logic [LW-1:0]       lock_nxt;
    logic                good;

    // Two-stage RX pipeline: current and previous received word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cur  <= '0;
            rx_prev <= '0;
        end else begin
            rx_cur  <= data_rx;
            rx_prev <= rx_cur;
        end
    end

    // A word is good only when every lane advanced by exactly one (mod 2^16).
    always_comb begin
        good = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (rx_cur[16*i +: 16] != rx_prev[16*i +: 16] + 16'd1) begin
                good = 1'b0;
            end
        end
    end

    // Next lock count: saturating run length of good words.
    always_comb begin
        lock_nxt = lock_cnt;
        if (!good) begin
            lock_nxt = '0;
        end else if (lock_cnt != LOCK_MAX) begin
            lock_nxt = lock_cnt + LW'(1);
        end
    end

    // Lock state: cleared while aligning, sticky once the run is long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (clear) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (enable) begin
            lock_cnt <= lock_nxt;
            if (lock_nxt == LOCK_MAX) begin
                locked <= 1'b1;
            end
        end
    end

    assign delay_mode = skew_code(rx_cur[15:0], rx_cur[31:16]);

endmodule

// File: rtl/ol_link_controller.sv
// ol_link_controller: per-link bring-up sequencer IDLE -> ALIGN -> TEST -> DATA.
// Drives alignment and counter patterns, judges the test, retries, then passes payload.
module ol_link_controller
    import ol_pkg::*;
#(
    parameter int          LANES        = 2,
    parameter int          ALIGN_CYCLES = 1044207,
    parameter int          ALIGN_GUARD  = 4370,
    parameter int          TEST_CYCLES  = 4369,
    parameter int          LOCK_COUNT   = 2047,
    parameter int          MAX_RETRY    = 3,
    parameter logic [15:0] ALIGN_WORD   = OL_ALIGN_WORD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  LIVE,
    input  logic                  retrain,
    input  logic [16*LANES-1:0]   data_tx,
    input  logic [16*LANES-1:0]   data_rx,
    input  logic                  ena_rx,
    output logic [16*LANES-1:0]   data_out,
    output logic                  ena_tx,
    output logic [2*LANES-1:0]    datak,
    output logic                  error,
    output logic                  send_err,
    output logic [1:0]            delay_mode,
    output logic                  link_up,
    output logic [1:0]            retry_cnt
);

    localparam int W    = 16 * LANES;
    localparam int CMAX = (ALIGN_CYCLES > TEST_CYCLES) ? ALIGN_CYCLES : TEST_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] A_LAST = CW'(ALIGN_CYCLES - 1);
    localparam logic [CW-1:0] T_LAST = CW'(TEST_CYCLES - 1);
    localparam logic [CW:0]   A_OPEN = (CW+1)'(ALIGN_CYCLES - ALIGN_GUARD);

    ol_state_t            state;
    ol_state_t            state_n;
    logic [CW-1:0]        control;
    logic [CW-1:0]        control_n;
    logic [15:0]          lcnt;
    logic [15:0]          lcnt_n;
    logic                 live_q;
    logic                 finish;
    logic                 test_err;
    logic                 retry_ok;
    logic [1:0]           rc_n;
    logic                 err_n;
    logic [1:0]           dm_n;
    logic [W-1:0]         dout_n;
    logic [2*LANES-1:0]   k_n;
    logic                 tx_n;
    logic                 chk_locked;
    logic [1:0]           chk_dm;

    assign lcnt_n   = lcnt + 16'd1;
    assign test_err = ena_rx ? ~chk_locked : 1'b0;
    assign retry_ok = (MAX_RETRY != 0) && (int'(retry_cnt) < MAX_RETRY);

    ol_pattern_checker #(
        .LANES      (LANES),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state == ST_ALIGN),
        .enable     (state == ST_TEST),
        .data_rx    (data_rx),
        .locked     (chk_locked),
        .delay_mode (chk_dm)
    );

    // Next state and phase counter; LIVE low beats retrain beats sequencing.
    always_comb begin
        state_n   = state;
        control_n = control;
        finish    = 1'b0;
        rc_n      = retry_cnt;
        if (!LIVE) begin
            state_n   = ST_ALIGN;
            control_n = '0;
        end else if (retrain && state == ST_DATA) begin
            state_n   = ST_ALIGN;
            control_n = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                end
                ST_ALIGN: begin
                    if (control == A_LAST) begin
                        state_n   = ST_TEST;
                        control_n = '0;
                    end else begin
                        control_n = control + CW'(1);
                    end
                end
                ST_TEST: begin
                    if (control == T_LAST) begin
                        finish    = 1'b1;
                        control_n = '0;
                        if (test_err && retry_ok) begin
                            state_n = ST_ALIGN;
                            rc_n    = (retry_cnt == 2'b11) ? retry_cnt : retry_cnt + 2'd1;
                        end else begin
                            state_n = ST_DATA;
                        end
                    end else begin
                        control_n = control + CW'(1);
                    end
                end
                ST_DATA: begin
                end
            endcase
        end
        if (LIVE && !live_q) begin
            rc_n = 2'd0;
        end
    end

    // Next output values, aligned with the state/phase they belong to.
    always_comb begin
        dout_n = '0;
        k_n    = '0;
        tx_n   = 1'b1;
        unique case (state_n)
            ST_IDLE: begin
            end
            ST_ALIGN: begin
                dout_n[15:0] = ALIGN_WORD;
                for (int i = 1; i < LANES; i++) begin
                    dout_n[16*i +: 16] = lcnt_n;
                end
                if ({1'b0, control_n} < A_OPEN) begin
                    k_n[1:0] = 2'b11;
                    tx_n     = 1'b0;
                end
            end
            ST_TEST: begin
                for (int i = 0; i < LANES; i++) begin
                    dout_n[16*i +: 16] = lcnt_n + 16'(i);
                end
            end
            ST_DATA: begin
                dout_n = data_tx;
            end
        endcase
        err_n = error;
        dm_n  = delay_mode;
        if (!LIVE) begin
            err_n = 1'b1;
        end else if (finish) begin
            err_n = test_err;
            dm_n  = chk_dm;
        end
    end

    // Sequencer state, phase counter, pattern counter and LIVE history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            control <= '0;
            lcnt    <= '0;
            live_q  <= 1'b0;
        end else begin
            state   <= state_n;
            control <= control_n;
            lcnt    <= lcnt_n;
            live_q  <= LIVE;
        end
    end

    // Registered link outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            datak      <= '0;
            ena_tx     <= 1'b1;
            error      <= 1'b1;
            send_err   <= 1'b0;
            delay_mode <= DM_ADJ;
            link_up    <= 1'b0;
            retry_cnt  <= 2'd0;
        end else begin
            data_out   <= dout_n;
            datak      <= k_n;
            ena_tx     <= tx_n;
            error      <= err_n;
            send_err   <= finish;
            delay_mode <= dm_n;
            link_up    <= (state_n == ST_DATA);
            retry_cnt  <= rc_n;
        end
    end

endmodule

// File: tb/tb_ol_link_controller.sv
// tb_ol_link_controller: directed bench for the link bring-up controller.
// Short ALIGN/TEST lengths, loopback RX with optional bit flips and lane skew.
module tb_ol_link_controller;

    localparam int W = 32;
    localparam logic [43:0] RESET_OUTS = {32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          LIVE;
    logic          retrain;
    logic          ena_rx;
    logic [W-1:0]  data_tx;
    logic [W-1:0]  data_rx;
    logic [W-1:0]  data_out;
    logic          ena_tx;
    logic [3:0]    datak;
    logic          error;
    logic          send_err;
    logic [1:0]    delay_mode;
    logic          link_up;
    logic [1:0]    retry_cnt;

    logic          rx_loop;
    logic          flip_en;
    logic [1:0]    skew;
    logic [W-1:0]  rx_drv;
    logic [15:0]   rx_l1;
    int            cyc = 0;
    int            n_pass = 0;
    int            n_total = 0;

    always #5 clk = ~clk;

    always @(negedge clk) cyc <= cyc + 1;

    always_comb begin
        rx_l1 = data_out[31:16];
        if (skew == 2'd1) begin
            rx_l1 = data_out[31:16] - 16'd3;
        end else if (skew == 2'd2) begin
            rx_l1 = data_out[31:16] + 16'h1234;
        end
        data_rx = rx_drv;
        if (rx_loop) begin
            data_rx = {rx_l1, data_out[15:0]};
            if (flip_en && (cyc % 10 == 0)) begin
                data_rx[0] = ~data_rx[0];
            end
        end
    end

    ol_link_controller #(
        .LANES        (2),
        .ALIGN_CYCLES (64),
        .ALIGN_GUARD  (8),
        .TEST_CYCLES  (32),
        .LOCK_COUNT   (16),
        .MAX_RETRY    (3),
        .ALIGN_WORD   (16'h50BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .LIVE       (LIVE),
        .retrain    (retrain),
        .data_tx    (data_tx),
        .data_rx    (data_rx),
        .ena_rx     (ena_rx),
        .data_out   (data_out),
        .ena_tx     (ena_tx),
        .datak      (datak),
        .error      (error),
        .send_err   (send_err),
        .delay_mode (delay_mode),
        .link_up    (link_up),
        .retry_cnt  (retry_cnt)
    );

    function automatic logic [43:0] outs();
        return {data_out, datak, ena_tx, error, send_err, delay_mode, link_up, retry_cnt};
    endfunction

    task automatic pulse_live();
        LIVE = 1'b0;
        @(negedge clk);
        LIVE = 1'b1;
    endtask

    task automatic wait_send_err(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i <= budget; i++) begin
            if (send_err === 1'b1) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0; LIVE = 1'b1; retrain = 1'b0; ena_rx = 1'b1;
        data_tx = '0; rx_loop = 1'b1; flip_en = 1'b0; skew = 2'd0; rx_drv = '0;
        #12;
        n_total++;
        if (ena_tx !== 1'b1) $display("FAIL rst_ena_tx: got %b want 1", ena_tx);
        else n_pass++;
        n_total++;
        if (error !== 1'b1) $display("FAIL rst_error: got %b want 1", error);
        else n_pass++;
        n_total++;
        if (outs() !== RESET_OUTS) $display("FAIL rst_outs: got %h want %h", outs(), RESET_OUTS);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        data_tx = 32'hA5A5_0F0F;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            retrain = (i == 50);
            @(negedge clk);
            if (outs() !== RESET_OUTS) bad++;
        end
        retrain = 1'b0;
        n_total++;
        if (bad != 0) $display("FAIL idle_hold: %0d cycles off reset values, want 0", bad);
        else n_pass++;
    endtask

    task automatic test_align_pass();
        int bad_win, bad_guard, lat;
        logic [15:0] d;
        pulse_live();
        bad_win = 0; bad_guard = 0;
        for (int i = 0; i < 64; i++) begin
            if (i < 56) begin
                if (ena_tx !== 1'b0 || datak !== 4'b0011 || data_out[15:0] !== 16'h50BC) bad_win++;
            end else begin
                if (ena_tx !== 1'b1 || datak !== 4'b0000) bad_guard++;
            end
            @(negedge clk);
        end
        n_total++;
        if (bad_win != 0) $display("FAIL align_window: %0d bad cycles, want 0", bad_win);
        else n_pass++;
        n_total++;
        if (bad_guard != 0) $display("FAIL align_guard: %0d bad cycles, want 0", bad_guard);
        else n_pass++;
        d = data_out[31:16] - data_out[15:0];
        n_total++;
        if (ena_tx !== 1'b1 || datak !== 4'b0 || d !== 16'd1)
            $display("FAIL test_pattern: ena_tx %b datak %b diff %h want 1 0 1", ena_tx, datak, d);
        else n_pass++;
        wait_send_err(100, lat);
        n_total++;
        if (lat != 32) $display("FAIL send_err_latency: got %0d want 32", lat);
        else n_pass++;
        n_total++;
        if ({error, delay_mode, link_up, retry_cnt} !== {1'b0, 2'd0, 1'b1, 2'd0})
            $display("FAIL pass_result: err %b dm %0d up %b rc %0d want 0 0 1 0",
                     error, delay_mode, link_up, retry_cnt);
        else n_pass++;
        data_tx = 32'hCAFE_1234;
        @(negedge clk);
        n_total++;
        if (send_err !== 1'b0 || link_up !== 1'b1)
            $display("FAIL send_err_once: send_err %b link_up %b want 0 1", send_err, link_up);
        else n_pass++;
        n_total++;
        if (data_out !== 32'hCAFE_1234) $display("FAIL data_pass: got %h want cafe1234", data_out);
        else n_pass++;
    endtask

    task automatic test_retrain_live();
        int n;
        retrain = 1'b1;
        @(negedge clk);
        retrain = 1'b0;
        n_total++;
        if (link_up !== 1'b0 || ena_tx !== 1'b0 || datak !== 4'b0011)
            $display("FAIL retrain_enter: up %b ena_tx %b datak %b want 0 0 0011", link_up, ena_tx, datak);
        else n_pass++;
        repeat (60) @(negedge clk);
        retrain = 1'b1;
        @(negedge clk);
        retrain = 1'b0;
        n_total++;
        if (ena_tx !== 1'b1 || datak !== 4'b0)
            $display("FAIL retrain_ignored: ena_tx %b datak %b want 1 0", ena_tx, datak);
        else n_pass++;
        repeat (3 + 10) @(negedge clk);
        pulse_live();
        n_total++;
        if (ena_tx !== 1'b0 || datak !== 4'b0011 || error !== 1'b1 || link_up !== 1'b0)
            $display("FAIL live_low_test: ena_tx %b datak %b err %b up %b want 0 0011 1 0",
                     ena_tx, datak, error, link_up);
        else n_pass++;
        n = 0;
        while (ena_tx === 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n != 56) $display("FAIL live_restart_len: got %0d want 56", n);
        else n_pass++;
    endtask

    task automatic test_retry();
        int lat;
        logic [1:0] rc_exp;
        flip_en = 1'b1;
        pulse_live();
        for (int k = 1; k <= 4; k++) begin
            rc_exp = (k >= 3) ? 2'd3 : 2'(k);
            wait_send_err(200, lat);
            n_total++;
            if (lat < 0 || error !== 1'b1 || retry_cnt !== rc_exp || link_up !== (k == 4))
                $display("FAIL retry_%0d: lat %0d err %b rc %0d up %b want err 1 rc %0d up %b",
                         k, lat, error, retry_cnt, link_up, rc_exp, (k == 4));
            else n_pass++;
            @(negedge clk);
        end
        flip_en = 1'b0;
        retrain = 1'b1;
        @(negedge clk);
        retrain = 1'b0;
        n_total++;
        if (retry_cnt !== 2'd3 || link_up !== 1'b0)
            $display("FAIL retry_hold: rc %0d up %b want 3 0", retry_cnt, link_up);
        else n_pass++;
        pulse_live();
        @(negedge clk);
        n_total++;
        if (retry_cnt !== 2'd0) $display("FAIL retry_clear: got %0d want 0", retry_cnt);
        else n_pass++;
    endtask

    task automatic test_skew(input logic [1:0] mode, input logic [1:0] dm_exp);
        int lat;
        skew = mode;
        pulse_live();
        wait_send_err(200, lat);
        n_total++;
        if (lat < 0 || error !== 1'b0 || delay_mode !== dm_exp || link_up !== 1'b1)
            $display("FAIL skew_%0d: lat %0d err %b dm %0d up %b want err 0 dm %0d up 1",
                     mode, lat, error, delay_mode, link_up, dm_exp);
        else n_pass++;
        skew = 2'd0;
    endtask

    task automatic test_ena_rx();
        int lat;
        flip_en = 1'b1;
        ena_rx = 1'b0;
        pulse_live();
        wait_send_err(200, lat);
        n_total++;
        if (lat < 0 || error !== 1'b0 || link_up !== 1'b1 || retry_cnt !== 2'd0)
            $display("FAIL ena_rx_low: lat %0d err %b up %b rc %0d want err 0 up 1 rc 0",
                     lat, error, link_up, retry_cnt);
        else n_pass++;
        flip_en = 1'b0;
        ena_rx = 1'b1;
    endtask

    task automatic test_wrap();
        logic [15:0] r;
        rx_loop = 1'b0;
        rx_drv = '0;
        pulse_live();
        repeat (64) @(negedge clk);
        r = 16'hFFF0;
        for (int k = 0; k < 32; k++) begin
            rx_drv = {r + 16'd1, r};
            @(negedge clk);
            r = r + 16'd1;
        end
        n_total++;
        if (send_err !== 1'b1 || error !== 1'b0 || delay_mode !== 2'd0)
            $display("FAIL lane_wrap: send_err %b err %b dm %0d want 1 0 0", send_err, error, delay_mode);
        else n_pass++;
        rx_loop = 1'b1;
    endtask

    task automatic test_reset_mid_align();
        pulse_live();
        repeat (20) @(negedge clk);
        n_total++;
        if (ena_tx !== 1'b0 || datak !== 4'b0011)
            $display("FAIL mid_align_pre: ena_tx %b datak %b want 0 0011", ena_tx, datak);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (outs() !== RESET_OUTS) $display("FAIL async_reset: got %h want %h", outs(), RESET_OUTS);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_total++;
        if (outs() !== RESET_OUTS) $display("FAIL idle_after_reset: got %h want %h", outs(), RESET_OUTS);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_align_pass();
        test_retrain_live();
        test_retry();
        test_skew(2'd1, 2'd1);
        test_skew(2'd2, 2'd2);
        test_ena_rx();
        test_wrap();
        test_reset_mid_align();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
